fft_frame_buffer: RTL and testbench
===================================

Name: fft_frame_buffer

Overview:
- Upstream input stage for the parallel FFT core.
- Accepts a serial stream of packed complex samples under a valid/ready handshake and assembles frames of N samples.
- Presents each complete frame as a parallel N-sample vector, matching the FFT core's data_in layout: sample[7:0] real, sample[15:8] imaginary, both signed.
- Ping-pong (two-bank) storage lets the next frame fill while the current frame waits for the consumer.

Parameters:
- N, 8, samples per frame; power of two, N >= 2.
- SAMPLE_WIDTH, 16, bits per packed complex sample (low half real, high half imag).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- s_valid  input  1  upstream sample valid.
- s_ready  output  1  buffer can accept a sample this cycle.
- s_data  input  SAMPLE_WIDTH  upstream sample.
- m_valid  output  1  complete frame available on m_data.
- m_ready  input  1  consumer takes the frame this cycle.
- m_data  output  N x SAMPLE_WIDTH (packed [N-1:0][SAMPLE_WIDTH-1:0])  frame; element i is frame sample i.
- frames_held  output  2  number of full banks (0, 1 or 2).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- State:
  - bank0 and bank1, each N x SAMPLE_WIDTH.
  - full[1:0] flags.
  - wr_sel and rd_sel (1 bit each).
  - wr_idx (log2 N bits).
- Reset (rst high at an edge):
  - full = 0, wr_sel = 0, rd_sel = 0, wr_idx = 0, both banks zeroed.
  - Outputs after reset: m_valid = 0, m_data = 0, frames_held = 0.
  - s_ready is forced 0 combinationally while rst is high, and is 1 on the first cycle after rst deasserts.
  - Reset mid-frame discards any partial frame and any held frames, with no output.
- Combinational outputs:
  - s_ready = !rst && !full[wr_sel].
  - m_valid = full[rd_sel].
  - m_data = bank[rd_sel].
  - frames_held = full[0] + full[1].
- Input accept (s_valid && s_ready):
  - Write bank[wr_sel][wr_idx] = s_data.
  - If wr_idx == N-1: set full[wr_sel], toggle wr_sel, set wr_idx = 0.
  - Otherwise increment wr_idx.
  - s_data is ignored when s_valid or s_ready is low.
- Output accept (m_valid && m_ready): clear full[rd_sel] and toggle rd_sel. m_ready while m_valid is low has no effect.
- Occupancy state machine, on frames_held:
  - EMPTY (0) -> ONE on frame completion.
  - ONE -> TWO on completion without drain.
  - ONE -> EMPTY on drain without completion.
  - ONE stays ONE on simultaneous completion and drain: the banks differ, so the set and the clear never collide.
  - TWO -> ONE on drain. In TWO, s_ready = 0.
- Latency: the last sample of a frame is accepted at edge t; m_valid is high in the cycle after edge t.
- Throughput: sustained one sample per cycle provided the consumer takes each frame within N cycles of m_valid rising.
- Stability: m_data and m_valid stay stable while m_valid && !m_ready. Frame contents never change until drained.
- Ordering: frames are delivered strictly in arrival order.
- Back-pressure: s_valid may stay high while s_ready is low. The sample is taken on the first cycle s_ready rises. No sample is dropped or duplicated.

Optional Feature:
- Macro: FFT_FRAME_BUFFER_BITREV_EN.
- Defined: the write address is bit_reverse(wr_idx) over log2 N bits, so m_data is in bit-reversed order for a DIT core. For N = 8, the slot order for arrival indices 0..7 is 0, 4, 2, 6, 1, 5, 3, 7. wr_idx counting, frame completion and the handshake are unchanged.
- Undefined: natural order, element i = i-th accepted sample.

Test Plan:
- Reset, then s_valid=1 with s_data = 16'h0100 + i for i = 0..7 back-to-back and m_ready=1:
  - m_valid pulses for one cycle, the cycle after the 8th accept.
  - m_data[i] = 16'h0100 + i (natural build).
  - frames_held returns to 0.
- m_ready=0, stream 16 samples continuously:
  - frames_held goes 1, then 2.
  - s_ready drops to 0 the cycle after the 16th accept.
  - A 17th sample held on s_data is not taken.
  - Raising m_ready for one cycle drains frame 0. m_data then shows frame 1, s_ready returns to 1, and the 17th sample is accepted.
- Simultaneous event: with frames_held=1, the 8th sample of the next frame is accepted in the same cycle as m_ready=1. frames_held stays 1 and m_data switches to the new frame.
- Random s_valid gaps (about 50%) and random m_ready over 64 frames of $random data: a scoreboard confirms every frame matches in order, with no drops or duplicates.
- Assert rst after 5 samples of a frame with frames_held=1:
  - On the next cycle m_valid=0, frames_held=0 and m_data=0.
  - The next 8 samples form a clean frame.
- With FFT_FRAME_BUFFER_BITREV_EN defined, feed samples 0..7 valued 0..7: m_data = {7,3,5,1,6,2,4,0}, element 7 first.

Source files
------------

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: ping-pong frame assembler in front of the parallel FFT core.
// Collects N serial complex samples (valid/ready) into one bank while the
// other bank holds a finished frame for the consumer.
// Optional build macro: FFT_FRAME_BUFFER_BITREV_EN (bit-reversed write slots).
module fft_frame_buffer #(
    parameter int N            = 8,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [SAMPLE_WIDTH-1:0]            s_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [N-1:0][SAMPLE_WIDTH-1:0]     m_data,
    output logic [1:0]                         frames_held
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

    logic [1:0][N-1:0][SAMPLE_WIDTH-1:0] bank_q;
    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] wr_addr;
    occ_e          occ_q, occ_d;

    logic in_acc, out_acc, last;

    assign s_ready     = !rst && !full_q[wr_sel_q];
    assign m_valid     = full_q[rd_sel_q];
    assign m_data      = bank_q[rd_sel_q];
    assign frames_held = occ_q;

    assign in_acc  = s_valid && s_ready;
    assign out_acc = m_valid && m_ready;
    assign last    = (wr_idx_q == IW'(N - 1));

    // Write slot: natural order, or bit-reversed index for a DIT core
    always_comb begin
        wr_addr = wr_idx_q;
`ifdef FFT_FRAME_BUFFER_BITREV_EN
        for (int b = 0; b < IW; b++) wr_addr[b] = wr_idx_q[IW-1-b];
`endif
    end

    // Next-state for bank flags and pointers; set and clear hit different banks
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_idx_d = wr_idx_q;
        if (in_acc) begin
            if (last) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
                wr_idx_d         = '0;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end
        if (out_acc) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
    end

    // Occupancy FSM: completion adds a frame, drain removes one, both cancel
    always_comb begin
        occ_d = occ_q;
        unique case (occ_q)
            EMPTY: if (in_acc && last) occ_d = ONE;
            ONE: begin
                if (in_acc && last && !out_acc)      occ_d = TWO;
                else if (out_acc && !(in_acc && last)) occ_d = EMPTY;
            end
            TWO:   if (out_acc) occ_d = ONE;
            default: occ_d = EMPTY;
        endcase
    end

    // State and bank storage; reset discards partial and held frames
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q   <= '0;
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_idx_q <= '0;
            occ_q    <= EMPTY;
        end else begin
            if (in_acc) bank_q[wr_sel_q][wr_addr] <= s_data;
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_idx_q <= wr_idx_d;
            occ_q    <= occ_d;
        end
    end
endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer: driver pushes expected frames into a queue,
// a monitor pops and compares each frame the DUT hands over.
module tb_fft_frame_buffer;
    localparam int N  = 8;
    localparam int SW = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     s_valid;
    logic                     s_ready;
    logic [SW-1:0]            s_data;
    logic                     m_valid;
    logic                     m_ready;
    logic [N-1:0][SW-1:0]     m_data;
    logic [1:0]               frames_held;

    typedef logic [N-1:0][SW-1:0] frame_t;

    frame_t exp_q[$];
    frame_t cur;
    int     cur_cnt = 0;
    int     errors  = 0;
    int     checks  = 0;
    bit     prod_done;

    fft_frame_buffer #(.N(N), .SAMPLE_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .frames_held(frames_held)
    );

    always #5 clk = ~clk;

    function automatic int slot(input int i);
        int r;
        r = i;
`ifdef FFT_FRAME_BUFFER_BITREV_EN
        r = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a frame is taken at the next edge when m_valid && m_ready
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL frame_unexpected: got %h expected none", m_data);
            end else begin
                chk("frame_data", m_data, exp_q.pop_front());
            end
        end
    end

    // Drive one sample and wait until it is accepted (bounded)
    task automatic send(input logic [SW-1:0] d);
        bit rdy;
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            @(negedge clk); rdy = s_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 500);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout: got stalled expected accept");
        end else begin
            cur[slot(cur_cnt)] = d;
            cur_cnt++;
            if (cur_cnt == N) begin
                exp_q.push_back(cur);
                cur_cnt = 0;
                cur = '0;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while (frames_held != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_empty", frames_held, 0);
        m_ready = 1'b0;
    endtask

    initial begin
        frame_t bexp;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; cur = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_held", frames_held, 0);
        chk("rst_m_data", m_data, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", s_ready, 1);

        // Back-to-back frame with consumer always ready
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) send(16'h0100 + 16'(i));
        chk("t1_m_valid_pulse", m_valid, 1);
        s_valid = 1'b0;
        @(posedge clk); #1;
        chk("t1_m_valid_low", m_valid, 0);
        chk("t1_held0", frames_held, 0);
        m_ready = 1'b0;

        // Fill both banks, back-pressure, then release one frame
        for (int i = 0; i < 2 * N; i++) begin
            send(16'h0200 + 16'(i));
            if (i == N - 1) chk("t2_held1", frames_held, 1);
        end
        chk("t2_held2", frames_held, 2);
        chk("t2_s_ready_low", s_ready, 0);
        s_data = 16'h0210;
        repeat (3) begin @(posedge clk); #1; end
        chk("t2_still_blocked", s_ready, 0);
        chk("t2_held_still2", frames_held, 2);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("t2_held_after_drain", frames_held, 1);
        chk("t2_s_ready_back", s_ready, 1);
        if (exp_q.size() != 0) chk("t2_frame1_shown", m_data, exp_q[0]);
        for (int i = 16; i < 24; i++) send(16'h0200 + 16'(i));
        chk("t2_held_again2", frames_held, 2);
        drain();

        // Completion and drain in the same cycle
        for (int i = 0; i < N; i++) send(16'h0300 + 16'(i));
        for (int i = 0; i < N - 1; i++) send(16'h0400 + 16'(i));
        m_ready = 1'b1;
        send(16'h0407);
        m_ready = 1'b0;
        s_valid = 1'b0;
        chk("t3_held_stays1", frames_held, 1);
        if (exp_q.size() != 0) chk("t3_new_frame_shown", m_data, exp_q[0]);
        drain();

        // Random gaps and random consumer over 64 frames
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 64 * N; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        s_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send(SW'($urandom));
                end
                s_valid = 1'b0;
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    m_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        chk("t4_all_delivered", exp_q.size(), 0);

        // Reset mid-frame with one frame held
        for (int i = 0; i < N; i++) send(16'h0500 + 16'(i));
        for (int i = 0; i < 5; i++) send(16'h0600 + 16'(i));
        s_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        cur = '0; cur_cnt = 0;
        @(posedge clk); #1;
        chk("t5_m_valid", m_valid, 0);
        chk("t5_held", frames_held, 0);
        chk("t5_m_data", m_data, 0);
        chk("t5_s_ready_in_rst", s_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) send(16'h0700 + 16'(i));
        chk("t5_clean_held", frames_held, 1);
        drain();

        // Ordering check with small values (bit-reversed build permutes slots)
        for (int i = 0; i < N; i++) send(16'(i));
        s_valid = 1'b0;
`ifdef FFT_FRAME_BUFFER_BITREV_EN
        bexp = {16'd7, 16'd3, 16'd5, 16'd1, 16'd6, 16'd2, 16'd4, 16'd0};
`else
        bexp = {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
`endif
        chk("t6_slot_order", m_data, bexp);
        drain();
        chk("end_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
